branch_predictor: RTL and testbench

Fetch-stage dynamic predictor for the pipelined RV32I core. Gives the fetch path a taken/not-taken guess for B-type instructions from a table of 2-bit saturating counters, and a predicted target for `jalr` from a direct-mapped jump target table (JTB). Its lookup outputs travel down the pipeline and become the prediction inputs of the branch judge. The execute-stage resolution, which is the same information the branch judge uses, returns here to train both tables. It also keeps resolved-branch and flush counters for performance measurement.

---
 rtl/branch_predictor.sv | 135 +++++++++++++
 tb/tb_branch_predictor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-stage predictor. A table of 2-bit saturating counters
//               predicts B-type branches, a direct-mapped jump target table
//               predicts jalr targets, and two saturating performance counters
//               track resolved branches and mispredict flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int BHT_ENTRIES = 64,
    parameter int JTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        B_type_prediction_result,
    output logic [31:0] jalr_jump_pc,
    output logic        jalr_pred_hit,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_B_type,
    input  logic        ex_taken,
    input  logic        ex_jalr,
    input  logic [31:0] ex_jalr_pc_actual,
    input  logic        PL_flush,
    output logic [31:0] br_cnt,
    output logic [31:0] flush_cnt
);

    localparam int c_BI = $clog2(BHT_ENTRIES);
    localparam int c_JI = $clog2(JTB_ENTRIES);
    localparam int c_TW = 30 - c_JI;

    logic [c_BI-1:0] w_if_bi;
    logic [c_BI-1:0] w_ex_bi;
    logic [c_JI-1:0] w_if_ji;
    logic [c_JI-1:0] w_ex_ji;
    logic            w_bht_upd;
    logic            w_jtb_upd;
    logic [1:0]      w_bht_cur;
    logic [1:0]      w_bht_next;
    logic            w_jtb_hit;
    logic            w_unused;

    logic [1:0]      w_bht_q     [BHT_ENTRIES];
    logic            w_jtb_valid [JTB_ENTRIES];
    logic [c_TW-1:0] w_jtb_tag   [JTB_ENTRIES];
    logic [31:0]     w_jtb_tgt   [JTB_ENTRIES];

    logic [31:0]     r_br_cnt;
    logic [31:0]     r_flush_cnt;

    assign w_if_bi   = if_pc[c_BI+1:2];
    assign w_ex_bi   = ex_pc[c_BI+1:2];
    assign w_if_ji   = if_pc[c_JI+1:2];
    assign w_ex_ji   = ex_pc[c_JI+1:2];
    assign w_bht_upd = ex_valid && ex_B_type;
    assign w_jtb_upd = ex_valid && ex_jalr;

    // Low PC bits and target bit 0 carry no information for the tables.
    assign w_unused = &{1'b0, ex_pc[1:0], ex_jalr_pc_actual[0]};

    always_comb begin
        w_bht_cur  = w_bht_q[w_ex_bi];
        w_bht_next = w_bht_cur;
        if (ex_taken) begin
            if (w_bht_cur != 2'd3) w_bht_next = w_bht_cur + 2'd1;
        end else begin
            if (w_bht_cur != 2'd0) w_bht_next = w_bht_cur - 2'd1;
        end
    end

    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
        localparam logic [c_BI-1:0] c_IDX = c_BI'(g);
        logic [1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= 2'd1;
            end else if (w_bht_upd && (w_ex_bi == c_IDX)) begin
                r_cnt <= w_bht_next;
            end
        end

        assign w_bht_q[g] = r_cnt;
    end

    for (genvar g = 0; g < JTB_ENTRIES; g++) begin : g_jtb
        localparam logic [c_JI-1:0] c_IDX = c_JI'(g);
        logic            r_valid;
        logic [c_TW-1:0] r_tag;
        logic [31:0]     r_target;

        // A tag conflict simply overwrites the resident entry.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
            end else if (w_jtb_upd && (w_ex_ji == c_IDX)) begin
                r_valid  <= 1'b1;
                r_tag    <= ex_pc[31:c_JI+2];
                r_target <= {ex_jalr_pc_actual[31:1], 1'b0};
            end
        end

        assign w_jtb_valid[g] = r_valid;
        assign w_jtb_tag[g]   = r_tag;
        assign w_jtb_tgt[g]   = r_target;
    end

    assign w_jtb_hit = w_jtb_valid[w_if_ji] && (w_jtb_tag[w_if_ji] == if_pc[31:c_JI+2]);

    assign B_type_prediction_result = w_bht_q[w_if_bi][1];
    assign jalr_pred_hit            = w_jtb_hit;
    assign jalr_jump_pc             = w_jtb_hit ? w_jtb_tgt[w_if_ji] : (if_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_cnt    <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (ex_valid && (ex_B_type || ex_jalr) && (r_br_cnt != 32'hFFFF_FFFF)) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (PL_flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign br_cnt    = r_br_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboard bench for branch_predictor lookups, training and
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        B_type_prediction_result;
    logic [31:0] jalr_jump_pc;
    logic        jalr_pred_hit;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_B_type;
    logic        ex_taken;
    logic        ex_jalr;
    logic [31:0] ex_jalr_pc_actual;
    logic        PL_flush;
    logic [31:0] br_cnt;
    logic [31:0] flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];

    branch_predictor #(
        .BHT_ENTRIES(64),
        .JTB_ENTRIES(16)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .if_pc                    (if_pc),
        .B_type_prediction_result (B_type_prediction_result),
        .jalr_jump_pc             (jalr_jump_pc),
        .jalr_pred_hit            (jalr_pred_hit),
        .ex_valid                 (ex_valid),
        .ex_pc                    (ex_pc),
        .ex_B_type                (ex_B_type),
        .ex_taken                 (ex_taken),
        .ex_jalr                  (ex_jalr),
        .ex_jalr_pc_actual        (ex_jalr_pc_actual),
        .PL_flush                 (PL_flush),
        .br_cnt                   (br_cnt),
        .flush_cnt                (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       obs = {31'd0, B_type_prediction_result};
                1:       obs = {31'd0, jalr_pred_hit};
                2:       obs = jalr_jump_pc;
                3:       obs = br_cnt;
                default: obs = flush_cnt;
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid          = 1'b0;
        ex_B_type         = 1'b0;
        ex_taken          = 1'b0;
        ex_jalr           = 1'b0;
        ex_pc             = 32'd0;
        ex_jalr_pc_actual = 32'd0;
        PL_flush          = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic pred,
                          input logic hit, input logic [31:0] tgt);
        if_pc = pc;
        push({tag, "_pred"}, 0, {31'd0, pred});
        push({tag, "_hit"},  1, {31'd0, hit});
        push({tag, "_tgt"},  2, tgt);
        #1;
        drain();
    endtask

    task automatic counters(input string tag, input logic [31:0] br, input logic [31:0] fl);
        push({tag, "_br"},    3, br);
        push({tag, "_flush"}, 4, fl);
        drain();
    endtask

    task automatic bht_upd(input logic [31:0] pc, input logic taken, input logic valid);
        ex_valid  = valid;
        ex_B_type = 1'b1;
        ex_pc     = pc;
        ex_taken  = taken;
        tick();
        idle_inputs();
    endtask

    task automatic jalr_upd(input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid          = 1'b1;
        ex_jalr           = 1'b1;
        ex_pc             = pc;
        ex_jalr_pc_actual = tgt;
        tick();
        idle_inputs();
    endtask

    task automatic flush_pulse(input logic valid);
        ex_valid = valid;
        PL_flush = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        if_pc = 32'd0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        counters("rst_cnt", 32'd0, 32'd0);
        lookup("rst_100",  32'h0000_0100, 1'b0, 1'b0, 32'h0000_0104);
        lookup("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // Saturation up: 1 -> 2 -> 3 -> 3 -> 3
        bht_upd(32'h40, 1'b1, 1'b1);
        lookup("sat_t1", 32'h40, 1'b1, 1'b0, 32'h44);
        for (int i = 0; i < 3; i++) bht_upd(32'h40, 1'b1, 1'b1);
        lookup("sat_t4", 32'h40, 1'b1, 1'b0, 32'h44);
        bht_upd(32'h40, 1'b0, 1'b1);
        lookup("sat_n1", 32'h40, 1'b1, 1'b0, 32'h44);
        bht_upd(32'h40, 1'b0, 1'b1);
        lookup("sat_n2", 32'h40, 1'b0, 1'b0, 32'h44);
        bht_upd(32'h40, 1'b0, 1'b1);
        bht_upd(32'h40, 1'b0, 1'b1);
        lookup("sat_n4", 32'h40, 1'b0, 1'b0, 32'h44);
        // Counter held at 0: one taken gives 1, two give 2
        bht_upd(32'h40, 1'b1, 1'b1);
        lookup("sat_up1", 32'h40, 1'b0, 1'b0, 32'h44);
        bht_upd(32'h40, 1'b1, 1'b1);
        lookup("sat_up2", 32'h40, 1'b1, 1'b0, 32'h44);
        counters("cnt_bht", 32'd10, 32'd0);

        lookup("alias_140", 32'h140, 1'b1, 1'b0, 32'h144);
        bht_upd(32'h40, 1'b0, 1'b0);
        bht_upd(32'h40, 1'b0, 1'b0);
        lookup("bubble_40", 32'h40, 1'b1, 1'b0, 32'h44);
        counters("cnt_bubble", 32'd10, 32'd0);

        jalr_upd(32'h200, 32'h1235);
        lookup("jtb_fill", 32'h200, 1'b0, 1'b1, 32'h1234);
        lookup("jtb_conf", 32'h240, 1'b1, 1'b0, 32'h244);
        jalr_upd(32'h240, 32'h3000);
        lookup("jtb_evict", 32'h200, 1'b0, 1'b0, 32'h204);
        lookup("jtb_new",   32'h240, 1'b1, 1'b1, 32'h3000);

        // Same-cycle update and lookup on a fresh counter (1 -> 2)
        if_pc     = 32'h80;
        ex_valid  = 1'b1;
        ex_B_type = 1'b1;
        ex_taken  = 1'b1;
        ex_pc     = 32'h80;
        #1;
        push("same_cyc", 0, 32'd0);
        drain();
        tick();
        idle_inputs();
        push("next_cyc", 0, 32'd1);
        drain();
        counters("cnt_pre", 32'd13, 32'd0);

        for (int i = 0; i < 3; i++) bht_upd(32'h300 + 32'(i * 4), 1'b0, 1'b1);
        jalr_upd(32'h380, 32'h4000);
        jalr_upd(32'h384, 32'h4100);
        counters("cnt_br5", 32'd18, 32'd0);

        flush_pulse(1'b1);
        flush_pulse(1'b0);
        flush_pulse(1'b1);
        counters("cnt_flush3", 32'd18, 32'd3);

        force dut.r_flush_cnt = 32'hFFFF_FFFF;
        force dut.r_br_cnt    = 32'hFFFF_FFFF;
        #1;
        release dut.r_flush_cnt;
        release dut.r_br_cnt;
        ex_valid  = 1'b1;
        ex_B_type = 1'b1;
        ex_pc     = 32'h500;
        PL_flush  = 1'b1;
        tick();
        idle_inputs();
        counters("cnt_sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Mid-stream reset with an update and a flush pending
        rst_n     = 1'b0;
        ex_valid  = 1'b1;
        ex_B_type = 1'b1;
        ex_taken  = 1'b1;
        ex_pc     = 32'h40;
        PL_flush  = 1'b1;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        counters("mid_rst", 32'd0, 32'd0);
        lookup("mid_40",  32'h40,  1'b0, 1'b0, 32'h44);
        lookup("mid_80",  32'h80,  1'b0, 1'b0, 32'h84);
        lookup("mid_240", 32'h240, 1'b0, 1'b0, 32'h244);

        bht_upd(32'h40, 1'b1, 1'b1);
        lookup("post_rst", 32'h40, 1'b1, 1'b0, 32'h44);
        counters("post_cnt", 32'd1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
